tick_rate_controller: RTL and testbench

- Owns the programmable sample-rate clock-enable for the signal generator. Replaces free-running fixed dividers with one divider counter whose ratio requesters change through a valid/ready handshake.
- Emits a one-cycle TICK enable and a 50% square HALF_TICK_CLK derived from it, both on the CLOCK domain.
- New ratios take effect only on a period boundary, so every period runs fully at either the old ratio or the new one.

---
 rtl/tick_rate_controller_pkg.sv | 25 ++
 rtl/tick_rate_controller_if.sv | 28 ++
 rtl/tick_rate_controller_counter.sv | 53 +++++
 rtl/tick_rate_controller.sv | 113 +++++++++++
 tb/tb_tick_rate_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_rate_controller_pkg.sv
// Shared types and helpers for the tick rate controller (optional sweep: TICK_RATE_SWEEP_EN).
// Holds the handshake FSM states, the default counter width and the divisor clamp.
package tick_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 26;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Saturate a requested divisor into [lo, hi]; callers widen to 32 bits and truncate back.
  function automatic logic [31:0] clamp_div(input logic [31:0] div,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (div < lo) begin
      return lo;
    end else if (div > hi) begin
      return hi;
    end else begin
      return div;
    end
  endfunction

endpackage

// File: rtl/tick_rate_controller_if.sv
// Divisor request handshake between a requester (master) and the controller (slave).
// Shared by the default build and the TICK_RATE_SWEEP_EN build.
interface tick_rate_controller_if
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             REQ_VALID;
  logic [CNT_W-1:0] REQ_DIV;
  logic             REQ_READY;
  logic             REQ_ERR;

  modport master (
    output REQ_VALID,
    output REQ_DIV,
    input  REQ_READY,
    input  REQ_ERR
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_DIV,
    output REQ_READY,
    output REQ_ERR
  );

endinterface

// File: rtl/tick_rate_controller_counter.sv
// Divider counter: wrap detect, registered TICK, HALF_TICK_CLK toggle and divisor load on wrap.
// Identical in the default and TICK_RATE_SWEEP_EN builds; the top decides what to load.
module tick_counter
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT = 50000
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_div,
  output logic             wrap,
  output logic             tick,
  output logic             half_tick_clk,
  output logic [CNT_W-1:0] cur_div
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] cur_div_reg;
  logic             tick_reg;
  logic             half_reg;

  // Always compared against the divisor in force, so a pending change never truncates a period.
  always_comb begin
    wrap = (count_reg == (cur_div_reg - CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg   <= '0;
      cur_div_reg <= CNT_W'(DIV_DEFAULT);
      tick_reg    <= 1'b0;
      half_reg    <= 1'b0;
    end else begin
      tick_reg <= wrap;
      if (wrap) begin
        count_reg <= '0;
        half_reg  <= ~half_reg;
        if (load_en) begin
          cur_div_reg <= load_div;
        end
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign tick          = tick_reg;
  assign half_tick_clk = half_reg;
  assign cur_div       = cur_div_reg;

endmodule

// File: rtl/tick_rate_controller.sv
// Programmable sample-rate tick generator with a valid/ready divisor request port.
// Define TICK_RATE_SWEEP_EN to add the SWEEP_ON/SWEEP_STEP sawtooth divisor sweep.
module tick_rate_controller
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT = 50000,
  parameter int DIV_MIN     = 2,
  parameter int DIV_MAX     = 50000000
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  tick_rate_controller_if.slave  req,
`ifdef TICK_RATE_SWEEP_EN
  input  logic                   SWEEP_ON,
  input  logic [CNT_W-1:0]       SWEEP_STEP,
`endif
  output logic [CNT_W-1:0]       CUR_DIV,
  output logic                   TICK,
  output logic                   HALF_TICK_CLK
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] pend_div_reg;
  logic [CNT_W-1:0] pend_div_next;
  logic             err_reg;
  logic             err_next;
  logic             load_en;
  logic [CNT_W-1:0] load_div;
  logic             wrap;
  logic [CNT_W-1:0] cur_div;

`ifdef TICK_RATE_SWEEP_EN
  logic [CNT_W-1:0] sweep_div;

  // Stepping below DIV_MIN (or wrapping past zero) restarts the chirp at DIV_MAX.
  always_comb begin
    if ((cur_div < SWEEP_STEP) || ((cur_div - SWEEP_STEP) < CNT_W'(DIV_MIN))) begin
      sweep_div = CNT_W'(DIV_MAX);
    end else begin
      sweep_div = cur_div - SWEEP_STEP;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    pend_div_next = pend_div_reg;
    err_next      = 1'b0;
    load_en       = 1'b0;
    load_div      = pend_div_reg;
    case (state_reg)
      RUN: begin
        if (req.REQ_VALID) begin
          pend_div_next = CNT_W'(clamp_div(32'(req.REQ_DIV), 32'(DIV_MIN), 32'(DIV_MAX)));
          err_next      = (req.REQ_DIV < CNT_W'(DIV_MIN)) || (req.REQ_DIV > CNT_W'(DIV_MAX));
          state_next    = PENDING;
        end
`ifdef TICK_RATE_SWEEP_EN
        else if (SWEEP_ON && wrap) begin
          load_en  = 1'b1;
          load_div = sweep_div;
        end
`endif
      end
      PENDING: begin
        // The new divisor lands exactly on a period boundary.
        if (wrap) begin
          load_en    = 1'b1;
          load_div   = pend_div_reg;
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg    <= RUN;
      pend_div_reg <= CNT_W'(DIV_DEFAULT);
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_div_reg <= pend_div_next;
      err_reg      <= err_next;
    end
  end

  // Ready is shown high through reset; the reset branch above discards anything offered then.
  assign req.REQ_READY = RESET || (state_reg == RUN);
  assign req.REQ_ERR   = err_reg;

  tick_counter #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_counter (
    .clk           (CLOCK),
    .srst          (RESET),
    .load_en       (load_en),
    .load_div      (load_div),
    .wrap          (wrap),
    .tick          (TICK),
    .half_tick_clk (HALF_TICK_CLK),
    .cur_div       (cur_div)
  );

  assign CUR_DIV = cur_div;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Self-checking bench for tick_rate_controller; builds with or without TICK_RATE_SWEEP_EN.
// A behavioural period model is checked every cycle, plus hand-computed tick spacings.
module tb_tick_rate_controller;
  import tick_ctrl_pkg::*;

  localparam int CNT_W     = 26;
  localparam int DIV_DEF   = 4;
  localparam int DIV_MIN_P = 2;
`ifdef TICK_RATE_SWEEP_EN
  localparam int DIV_MAX_P = 10;
`else
  localparam int DIV_MAX_P = 50000000;
`endif

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic [CNT_W-1:0] CUR_DIV;
  logic             TICK;
  logic             HALF_TICK_CLK;
`ifdef TICK_RATE_SWEEP_EN
  logic             SWEEP_ON   = 1'b0;
  logic [CNT_W-1:0] SWEEP_STEP = '0;
`endif

  tick_rate_controller_if #(.CNT_W(CNT_W)) req ();

  tick_rate_controller #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEF),
    .DIV_MIN     (DIV_MIN_P),
    .DIV_MAX     (DIV_MAX_P)
  ) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .req           (req.slave),
`ifdef TICK_RATE_SWEEP_EN
    .SWEEP_ON      (SWEEP_ON),
    .SWEEP_STEP    (SWEEP_STEP),
`endif
    .CUR_DIV       (CUR_DIV),
    .TICK          (TICK),
    .HALF_TICK_CLK (HALF_TICK_CLK)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // Model state: position within the current period, divisor in force, pending divisor (-1 = none).
  int  m_pos, m_div, m_pend;
  bit  m_tick, m_half, m_err;
  bit  model_valid = 1'b0;
  int  edge_n = 0;
  int  err_cnt = 0;
  int  tick_q[$];
  int  div_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic int clamp_m(input int d);
    if (d < DIV_MIN_P) return DIV_MIN_P;
    if (d > DIV_MAX_P) return DIV_MAX_P;
    return d;
  endfunction

  function automatic int spacing(input int k);
    if (k < 1 || k >= tick_q.size()) return -1;
    return tick_q[k] - tick_q[k-1];
  endfunction

  // Model step and output compare, once per rising edge.
  always @(posedge CLOCK) begin
    bit rst, v, w, sw;
    int d, step, nd;
    rst  = RESET;
    v    = req.REQ_VALID;
    d    = int'(req.REQ_DIV);
    sw   = 1'b0;
    step = 0;
`ifdef TICK_RATE_SWEEP_EN
    sw   = SWEEP_ON;
    step = int'(SWEEP_STEP);
`endif
    if (rst) begin
      m_pos = 0; m_div = DIV_DEF; m_pend = -1;
      m_tick = 0; m_half = 0; m_err = 0;
      edge_n = 0; model_valid = 1'b1;
    end else if (model_valid) begin
      w = (m_pos == m_div - 1);
      edge_n++;
      m_tick = w;
      if (w) m_half = !m_half;
      m_err = 0;
      if (m_pend < 0) begin
        if (v) begin
          m_pend = clamp_m(d);
          m_err  = (d < DIV_MIN_P) || (d > DIV_MAX_P);
          $display("request accepted at edge %0d: div=%0d -> %0d err=%0b", edge_n, d, m_pend, m_err);
        end else if (sw && w) begin
          nd = m_div - step;
          m_div = (nd < DIV_MIN_P) ? DIV_MAX_P : nd;
        end
      end else if (w) begin
        m_div  = m_pend;
        m_pend = -1;
      end
      m_pos = w ? 0 : m_pos + 1;
    end
    #1;
    if (model_valid) begin
      check("tick", longint'(TICK), longint'(m_tick));
      check("half_tick_clk", longint'(HALF_TICK_CLK), longint'(m_half));
      check("cur_div", longint'(CUR_DIV), longint'(m_div));
      check("req_err", longint'(req.REQ_ERR), longint'(m_err));
      check("req_ready", longint'(req.REQ_READY), longint'(RESET || (m_pend < 0)));
      if (!rst) begin
        if (TICK) begin
          tick_q.push_back(edge_n);
          div_q.push_back(int'(CUR_DIV));
        end
        if (req.REQ_ERR) err_cnt++;
      end
    end
  end

  // Caller sits at a negedge; the request is held until the controller takes it.
  task automatic send_req(input int d);
    bit done;
    done = 1'b0;
    req.REQ_VALID = 1'b1;
    req.REQ_DIV   = CNT_W'(d);
    for (int i = 0; i < 200; i++) begin
      if (req.REQ_READY) begin
        done = 1'b1;
        break;
      end
      @(negedge CLOCK);
    end
    if (!done) timeout_fail("send_req");
    @(negedge CLOCK);
    req.REQ_VALID = 1'b0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK);
      if (TICK) return;
    end
    timeout_fail("wait_tick");
  endtask

  initial begin
    int idx;
    req.REQ_VALID = 1'b0;
    req.REQ_DIV   = '0;

    // Reset release with divisor 4: ticks on post-reset edges 4, 8, 12.
    repeat (3) @(negedge CLOCK);
    check("rst cur_div", longint'(CUR_DIV), 4);
    check("rst tick", longint'(TICK), 0);
    check("rst half", longint'(HALF_TICK_CLK), 0);
    check("rst ready", longint'(req.REQ_READY), 1);
    RESET = 1'b0;
    repeat (13) @(negedge CLOCK);
    check("boot tick count", tick_q.size(), 3);
    check("boot tick0", tick_q[0], 4);
    check("boot tick1", tick_q[1], 8);
    check("boot tick2", tick_q[2], 12);
    check("boot err", err_cnt, 0);

    // Divisor 6 accepted at count 1: spacings 4, 6, 6.
    idx = tick_q.size();
    send_req(6);
    check("pending ready", longint'(req.REQ_READY), 0);
    repeat (20) @(negedge CLOCK);
    check("to6 space0", spacing(idx), 4);
    check("to6 space1", spacing(idx + 1), 6);
    check("to6 space2", spacing(idx + 2), 6);
    check("to6 cur_div", longint'(CUR_DIV), 6);

    // Below-minimum request clamps to 2 with one error pulse.
    wait_tick();
    err_cnt = 0;
    send_req(1);
    repeat (12) @(negedge CLOCK);
    check("lo clamp cur_div", longint'(CUR_DIV), 2);
    check("lo clamp err", err_cnt, 1);

    // Request taken on a wrap edge (old 5, new 3): spacings 5, 5, 3.
    send_req(5);
    repeat (12) @(negedge CLOCK);
    check("to5 cur_div", longint'(CUR_DIV), 5);
    wait_tick();
    repeat (4) @(negedge CLOCK);
    idx = tick_q.size();
    send_req(3);
    repeat (20) @(negedge CLOCK);
    check("wrapreq space0", spacing(idx), 5);
    check("wrapreq space1", spacing(idx + 1), 5);
    check("wrapreq space2", spacing(idx + 2), 3);

    // Reset while 7 is pending: back to divisor 4, 7 never appears.
    send_req(5);
    repeat (12) @(negedge CLOCK);
    wait_tick();
    send_req(7);
    check("pend7 ready", longint'(req.REQ_READY), 0);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    tick_q.delete();
    check("rst2 cur_div", longint'(CUR_DIV), 4);
    check("rst2 ready", longint'(req.REQ_READY), 1);
    repeat (20) @(negedge CLOCK);
    check("rst2 tick0", (tick_q.size() > 0) ? tick_q[0] : -1, 4);
    check("rst2 space1", spacing(1), 4);
    check("rst2 space2", spacing(2), 4);
    check("rst2 cur_div late", longint'(CUR_DIV), 4);

`ifdef TICK_RATE_SWEEP_EN
    // Sweep from 6 by 2 within [2,10]: 4, 2, 10, 8.
    send_req(6);
    repeat (15) @(negedge CLOCK);
    check("sweep start", longint'(CUR_DIV), 6);
    SWEEP_STEP = CNT_W'(2);
    SWEEP_ON   = 1'b1;
    div_q.delete();
    repeat (40) @(negedge CLOCK);
    SWEEP_ON = 1'b0;
    check("sweep n", (div_q.size() >= 4) ? 1 : 0, 1);
    check("sweep d0", (div_q.size() > 0) ? div_q[0] : -1, 4);
    check("sweep d1", (div_q.size() > 1) ? div_q[1] : -1, 2);
    check("sweep d2", (div_q.size() > 2) ? div_q[2] : -1, 10);
    check("sweep d3", (div_q.size() > 3) ? div_q[3] : -1, 8);
    wait_tick();
`endif

    // Above-maximum request clamps to DIV_MAX with one error pulse.
    err_cnt = 0;
    send_req(60000000);
    repeat (12) @(negedge CLOCK);
    check("hi clamp cur_div", longint'(CUR_DIV), DIV_MAX_P);
    check("hi clamp err", err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
